tt_checker: RTL and testbench
=============================

// Module: tt_checker
// PURPOSE
//  Sequential truth-table checker for 2-input gate exercises: consumes (a,b,s) samples
//  from a gate under test through a valid/ready stream and checks each s against a
//  4-entry expected table, e.g. 4'b1001 for ~(a^b). Counts matches and misses, records
//  the first failing minterm and tracks minterm coverage. Sits between a vector source
//  and the self-checking bench; it is the result-reading end of the stimulus stream.
// PARAMETERS
//  CNT_W   8   width of the match/miss counters (and hit counters when enabled); saturating
// PORTS
//  clk            in   1      single clock, rising edge
//  rst_n          in   1      asynchronous reset, active low
//  start          in   1      1-cycle pulse: latch table_i, clear results, begin a session
//  table_i        in   4      expected s per minterm m={a,b}; table_i[m]
//  in_valid       in   1      sample valid
//  in_ready       out  1      checker accepts a sample; high only in RUN
//  in_a, in_b     in   1      gate inputs of the sample
//  in_s           in   1      gate output of the sample
//  in_last        in   1      marks the final sample of the session
//  busy           out  1      high in RUN
//  done           out  1      high in DONE; results are stable
//  pass           out  1      done && miss_cnt==0 && coverage==4'hF
//  match_cnt      out  CNT_W  samples with in_s==table[m]
//  miss_cnt       out  CNT_W  samples with in_s!=table[m]
//  first_miss_m   out  2      minterm of the first miss; valid when first_miss_vld
//  first_miss_vld out  1      a miss has occurred in this session
//  coverage       out  4      bit m set once minterm m has been sampled
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; every output 0, including in_ready, pass, counters
//    and coverage; latched table 0. Reset mid-session aborts with no residue.
//  - FSM IDLE->RUN on start. RUN->DONE on the cycle after a handshake with in_last=1.
//    DONE->RUN on start. start is ignored in RUN.
//  - On start (IDLE or DONE): table latched; counters, coverage, first_miss_* cleared;
//    all visible on the next cycle.
//  - Handshake: in_ready=(state==RUN). A sample is accepted when in_valid&&in_ready.
//    In IDLE/DONE, in_valid is ignored; the source must hold the sample.
//  - Accepted sample, m={in_a,in_b}: match_cnt or miss_cnt increments by 1, coverage[m]
//    sets, all in the following cycle (latency 1). First miss captures m and sets
//    first_miss_vld; later misses do not overwrite it.
//  - Counters saturate at 2^CNT_W-1 and never wrap.
//  - An accepted in_last sample is counted before done rises; done and the final
//    counters become visible in the same cycle.
//  - pass is combinational from registered state; it is 0 outside DONE.
// CONFIGURATION
//  TT_CHECKER_HIST_EN defined: extra output hit_cnt[4*CNT_W] with per-minterm saturating
//  sample counters, cleared on start and reset; slice m counts samples with {a,b}==m.
//  Not defined: the port and the counters are absent. The core behaviour is unchanged.
// STRUCTURE
//  tt_pkg: state enum {IDLE,RUN,DONE}; localparam NUM_MINTERMS=4; table constants
//  TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_XNOR=4'b1001.
//  Sub-module tt_sat_counter #(W) (clk, rst_n, clr, inc, q) is used for match, miss and
//  the hit counters.
// TESTING
//  1 start, table=4'b1001; send (00,1)(01,0)(10,0)(11,1 last) -> match=4 miss=0 cov=F pass=1
//  2 table=4'b1001; send (10,s=1) among the 4 vectors -> miss=1 first_miss_m=2 vld=1 pass=0
//  3 send only m0 and m3, both correct, last on m3 -> cov=4'b1001 miss=0 pass=0
//  4 CNT_W=4; 20 correct samples -> match_cnt=15, miss_cnt=0 (saturated, no wrap)
//  5 in_valid=1 while IDLE -> in_ready=0 and no count; drop rst_n mid-RUN -> all outputs 0
//  6 with TT_CHECKER_HIST_EN: m1 sent 3 times -> hit_cnt slice 1 =3; restart clears it to 0

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table checker: FSM states, minterm count,
// reference tables for the common 2-input gates and a minterm helper.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tt_state_e;

    localparam int NUM_MINTERMS = 4;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    // Minterm index m = {a,b}; also the bit position in a truth table.
    function automatic logic [1:0] minterm(input logic a, input logic b);
        return {a, b};
    endfunction

endpackage

// File: rtl/tt_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module tt_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Count register: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {W{1'b0}};
        end else if (clr) begin
            q_r <= {W{1'b0}};
        end else if (inc && (q_r != {W{1'b1}})) begin
            q_r <= q_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/tt_checker.sv
// Sequential truth-table checker for 2-input gates fed by a valid/ready sample stream.
// Optional per-minterm hit counters are enabled by defining TT_CHECKER_HIST_EN.
module tt_checker
    import tt_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       table_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_s,
    input  logic             in_last,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [1:0]       first_miss_m,
    output logic             first_miss_vld,
    output logic [3:0]       coverage
`ifdef TT_CHECKER_HIST_EN
    ,
    output logic [NUM_MINTERMS*CNT_W-1:0] hit_cnt
`endif
);

    tt_state_e  state_r;
    tt_state_e  state_s;
    logic [3:0] table_r;
    logic [3:0] coverage_r;
    logic [1:0] first_miss_m_r;
    logic       first_miss_vld_r;

    logic       start_s;
    logic       accept_s;
    logic [1:0] m_s;
    logic       match_s;
    logic       miss_s;

    // Sample classification against the latched table; start is ignored while running.
    always_comb begin
        start_s  = 1'b0;
        accept_s = 1'b0;
        m_s      = minterm(in_a, in_b);
        match_s  = 1'b0;
        miss_s   = 1'b0;
        if (state_r == RUN) begin
            accept_s = in_valid;
        end else begin
            start_s = start;
        end
        if (accept_s) begin
            match_s = (in_s == table_r[m_s]);
            miss_s  = (in_s != table_r[m_s]);
        end else begin
            match_s = 1'b0;
            miss_s  = 1'b0;
        end
    end

    // Next-state logic: the last accepted sample moves to DONE on the same edge it is counted.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_s = RUN;
                else         state_s = IDLE;
            end
            RUN: begin
                if (accept_s && in_last) state_s = DONE;
                else                     state_s = RUN;
            end
            DONE: begin
                if (start_s) state_s = RUN;
                else         state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Session results: table, coverage and the sticky first-miss record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_r          <= 4'b0000;
            coverage_r       <= 4'b0000;
            first_miss_m_r   <= 2'b00;
            first_miss_vld_r <= 1'b0;
        end else if (start_s) begin
            table_r          <= table_i;
            coverage_r       <= 4'b0000;
            first_miss_m_r   <= 2'b00;
            first_miss_vld_r <= 1'b0;
        end else if (accept_s) begin
            coverage_r[m_s] <= 1'b1;
            if (miss_s && !first_miss_vld_r) begin
                first_miss_m_r   <= m_s;
                first_miss_vld_r <= 1'b1;
            end
        end
    end

    tt_sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_s),
        .inc   (match_s),
        .q     (match_cnt)
    );

    tt_sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_s),
        .inc   (miss_s),
        .q     (miss_cnt)
    );

`ifdef TT_CHECKER_HIST_EN
    for (genvar i = 0; i < NUM_MINTERMS; i++) begin : g_hit
        logic hit_inc_s;
        assign hit_inc_s = accept_s && (m_s == 2'(i));
        tt_sat_counter #(.W(CNT_W)) u_hit_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start_s),
            .inc   (hit_inc_s),
            .q     (hit_cnt[i*CNT_W +: CNT_W])
        );
    end
`endif

    assign in_ready       = (state_r == RUN);
    assign busy           = (state_r == RUN);
    assign done           = (state_r == DONE);
    assign coverage       = coverage_r;
    assign first_miss_m   = first_miss_m_r;
    assign first_miss_vld = first_miss_vld_r;
    assign pass           = (state_r == DONE) && (miss_cnt == {CNT_W{1'b0}}) && (coverage_r == 4'hF);

endmodule

// File: tb/tb_tt_checker.sv
// Self-checking bench for tt_checker: directed sessions plus randomized sessions
// compared against a per-sample tally model of the truth-table rules.
module tb_tt_checker;
    import tt_pkg::*;

    localparam int CW   = 4;
    localparam int MAXV = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [3:0]    table_i;
    logic          in_valid;
    logic          in_ready;
    logic          in_a, in_b, in_s, in_last;
    logic          busy, done, pass;
    logic [CW-1:0] match_cnt, miss_cnt;
    logic [1:0]    first_miss_m;
    logic          first_miss_vld;
    logic [3:0]    coverage;
`ifdef TT_CHECKER_HIST_EN
    logic [4*CW-1:0] hit_cnt;
`endif

    always #5 clk = ~clk;

    tt_checker #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .table_i        (table_i),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_s           (in_s),
        .in_last        (in_last),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .match_cnt      (match_cnt),
        .miss_cnt       (miss_cnt),
        .first_miss_m   (first_miss_m),
        .first_miss_vld (first_miss_vld),
        .coverage       (coverage)
`ifdef TT_CHECKER_HIST_EN
        ,
        .hit_cnt        (hit_cnt)
`endif
    );

    int         errors = 0;
    int         checks = 0;
    // Reference model of one session
    logic [3:0] exp_tab;
    int         exp_match, exp_miss;
    int         exp_hit [4];
    logic [3:0] exp_cov;
    logic       exp_fmv;
    logic [1:0] exp_fm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input logic [3:0] t);
        exp_tab = t; exp_match = 0; exp_miss = 0; exp_cov = 4'b0000;
        exp_fmv = 1'b0; exp_fm = 2'b00;
        for (int i = 0; i < 4; i++) exp_hit[i] = 0;
    endtask

    task automatic check_state(input string tag, input bit exp_done);
        check({tag, ".match"}, 32'(match_cnt), 32'(exp_match));
        check({tag, ".miss"},  32'(miss_cnt),  32'(exp_miss));
        check({tag, ".cov"},   32'(coverage),  32'(exp_cov));
        check({tag, ".fmv"},   32'(first_miss_vld), 32'(exp_fmv));
        if (exp_fmv) check({tag, ".fm"}, 32'(first_miss_m), 32'(exp_fm));
        check({tag, ".done"},  32'(done),  32'(exp_done));
        check({tag, ".busy"},  32'(busy),  32'(!exp_done));
        check({tag, ".ready"}, 32'(in_ready), 32'(!exp_done));
        check({tag, ".pass"},  32'(pass), 32'(exp_done && exp_miss == 0 && exp_cov == 4'hF));
`ifdef TT_CHECKER_HIST_EN
        for (int i = 0; i < 4; i++) check({tag, ".hit"}, 32'(hit_cnt[i*CW +: CW]), 32'(exp_hit[i]));
`endif
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".match"}, 32'(match_cnt), 32'd0);
        check({tag, ".miss"},  32'(miss_cnt),  32'd0);
        check({tag, ".cov"},   32'(coverage),  32'd0);
        check({tag, ".fmv"},   32'(first_miss_vld), 32'd0);
        check({tag, ".fm"},    32'(first_miss_m), 32'd0);
        check({tag, ".done"},  32'(done), 32'd0);
        check({tag, ".busy"},  32'(busy), 32'd0);
        check({tag, ".ready"}, 32'(in_ready), 32'd0);
        check({tag, ".pass"},  32'(pass), 32'd0);
`ifdef TT_CHECKER_HIST_EN
        check({tag, ".hit"},   32'(hit_cnt), 32'd0);
`endif
    endtask

    task automatic start_session(input string tag, input logic [3:0] t);
        @(negedge clk);
        start = 1'b1; table_i = t;
        @(negedge clk);
        start = 1'b0; table_i = 4'b0000;
        model_clear(t);
        check_state(tag, 1'b0);
    endtask

    // Present one sample after an idle gap; check the tallies one cycle after acceptance.
    task automatic send(input string tag, input logic a, input logic b, input logic s,
                        input logic last, input int gap);
        int m;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_a = a; in_b = b; in_s = s; in_last = last; in_valid = 1'b1;
        check({tag, ".ready_pre"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        m = {30'd0, a, b};
        if (s == exp_tab[m]) begin
            exp_match = (exp_match < MAXV) ? exp_match + 1 : MAXV;
        end else begin
            exp_miss = (exp_miss < MAXV) ? exp_miss + 1 : MAXV;
            if (!exp_fmv) begin exp_fmv = 1'b1; exp_fm = 2'(m); end
        end
        exp_cov[m] = 1'b1;
        exp_hit[m] = (exp_hit[m] < MAXV) ? exp_hit[m] + 1 : MAXV;
        check_state(tag, last);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0] t;
        int         n, m;
        logic       s;

        rst_n = 1'b0; start = 1'b0; table_i = 4'b0000; in_valid = 1'b0;
        in_a = 1'b0; in_b = 1'b0; in_s = 1'b0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // Valid while IDLE is neither accepted nor counted
        in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1; in_s = 1'b1; in_last = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("idle_valid");
        in_valid = 1'b0; in_last = 1'b0;

        // Exhaustive correct XNOR session
        start_session("t1_start", TT_XNOR);
        send("t1_s0", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        send("t1_s1", 1'b0, 1'b1, 1'b0, 1'b0, 1);
        send("t1_s2", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        send("t1_s3", 1'b1, 1'b1, 1'b1, 1'b1, 2);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_ready_done", 32'(in_ready), 32'd0);

        // One wrong sample at minterm 2; restart from DONE clears results
        start_session("t2_start", 4'b1001);
        send("t2_s0", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        send("t2_s1", 1'b0, 1'b1, 1'b0, 1'b0, 0);
        send("t2_s2", 1'b1, 1'b0, 1'b1, 1'b0, 0);
        send("t2_s3", 1'b1, 1'b1, 1'b1, 1'b1, 0);
        check("t2_fm", 32'(first_miss_m), 32'd2);

        // Partial coverage
        start_session("t3_start", 4'b1001);
        send("t3_s0", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        send("t3_s3", 1'b1, 1'b1, 1'b1, 1'b1, 0);
        check("t3_cov", 32'(coverage), 32'h9);

        // start pulse during RUN must neither clear nor relatch the table
        start_session("t_ign_start", TT_AND);
        send("t_ign_s0", 1'b1, 1'b1, 1'b1, 1'b0, 0);
        start = 1'b1; table_i = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        check_state("t_ign_held", 1'b0);
        send("t_ign_s1", 1'b1, 1'b1, 1'b1, 1'b1, 0);

        // Saturation: 20 correct OR samples on a 4-bit counter
        start_session("t4_start", TT_OR);
        for (int i = 0; i < 20; i++) begin
            m = $urandom_range(0, 3);
            send("t4_sat", m[1], m[0], exp_tab[m], (i == 19), 0);
        end
        check("t4_match", 32'(match_cnt), 32'd15);

        // Randomized sessions with a mix of correct and wrong outputs
        for (int k = 0; k < 8; k++) begin
            t = 4'($urandom);
            n = $urandom_range(1, 12);
            start_session("rnd_start", t);
            for (int i = 0; i < n; i++) begin
                m = $urandom_range(0, 3);
                s = ($urandom_range(0, 3) == 0) ? ~exp_tab[m] : exp_tab[m];
                send("rnd", m[1], m[0], s, (i == n - 1), $urandom_range(0, 2));
            end
        end

`ifdef TT_CHECKER_HIST_EN
        // Minterm 1 three times, then restart clears the histogram
        start_session("t6_start", TT_XOR);
        send("t6_a", 1'b0, 1'b1, 1'b1, 1'b0, 0);
        send("t6_b", 1'b0, 1'b1, 1'b1, 1'b0, 1);
        send("t6_c", 1'b0, 1'b1, 1'b1, 1'b1, 0);
        check("t6_hit1", 32'(hit_cnt[CW +: CW]), 32'd3);
        start_session("t6_restart", TT_XOR);
        check("t6_hit1_clr", 32'(hit_cnt[CW +: CW]), 32'd0);
`endif

        // Asynchronous reset in the middle of a session
        start_session("t5_start", TT_XOR);
        send("t5_s0", 1'b0, 1'b1, 1'b0, 1'b0, 0);
        send("t5_s1", 1'b1, 1'b0, 1'b1, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("t5_async");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_a = 1'b0; in_b = 1'b0; in_s = 1'b0; in_last = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("t5_after");
        in_valid = 1'b0; in_last = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
